broadcast_scheduler: RTL and testbench

//  Sequences delivery of one MESSAGE_SIZE datagram from the control core to the four per-board

---
 rtl/broadcast_scheduler_pkg.sv | 13 +
 rtl/broadcast_scheduler_if.sv | 22 ++
 rtl/broadcast_scheduler_timer.sv | 27 ++
 rtl/broadcast_scheduler.sv | 116 +++++++++++
 tb/tb_broadcast_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/broadcast_scheduler_pkg.sv
// Shared constants and state encoding for the broadcast scheduler.
// BCAST_TIMEOUT_EN (optional define) enables channel timeout retirement.
package broadcast_scheduler_pkg;
  localparam int MESSAGE_SIZE = 32;
  localparam int N_CH         = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } bcast_state_t;
endpackage

// File: rtl/broadcast_scheduler_if.sv
// Frame intake and sender-channel bundle for the broadcast scheduler.
// master = scheduler side, slave = control core / sender channels.
interface broadcast_scheduler_if;
  import broadcast_scheduler_pkg::*;

  logic                    frame_valid;
  logic [MESSAGE_SIZE-1:0] frame_data;
  logic                    frame_ready;
  logic [N_CH-1:0]         ch_start;
  logic [MESSAGE_SIZE-1:0] ch_data;
  logic [N_CH-1:0]         ch_done;

  modport master (
    input  frame_valid, frame_data, ch_done,
    output frame_ready, ch_start, ch_data
  );

  modport slave (
    output frame_valid, frame_data, ch_done,
    input  frame_ready, ch_start, ch_data
  );
endinterface

// File: rtl/broadcast_scheduler_timer.sv
// WAIT-state watchdog: counts enabled cycles, flags the last permitted one.
// Only instantiated when BCAST_TIMEOUT_EN is defined.
module bcast_timeout_timer #(
  parameter int TIMEOUT = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == TW'(TIMEOUT - 1));
endmodule

// File: rtl/broadcast_scheduler.sv
// Broadcasts one latched frame to all live sender channels and waits for every done.
// BCAST_TIMEOUT_EN defined: stalled channels are retired into dead_mask after TIMEOUT cycles.
module broadcast_scheduler
  import broadcast_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 65536,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  broadcast_scheduler_if.master bus,
  input  logic [N_CH-1:0]       chan_en,
  input  logic                  revive,
  output logic [N_CH-1:0]       dead_mask,
  output logic                  bcast_done,
  output logic [CNT_W-1:0]      frame_count
);
  bcast_state_t            state_reg, state_next;
  logic [N_CH-1:0]         pending_reg, pending_next;
  logic [MESSAGE_SIZE-1:0] data_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [N_CH-1:0]         live;
  logic [N_CH-1:0]         pending_masked;
  logic                    expire;
  logic                    timed_out;

  assign live           = chan_en & ~dead_mask;
  assign pending_masked = pending_reg & ~bus.ch_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      data_reg    <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (state_reg == IDLE && bus.frame_valid) begin
        data_reg <= bus.frame_data;
      end
      if (state_reg == DONE) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    timed_out    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.frame_valid) state_next = ISSUE;
      end
      ISSUE: begin
        pending_next = live;
        state_next   = (live == '0) ? DONE : WAIT;
      end
      WAIT: begin
        // Done pulses are applied before the timeout test, so a late done still counts.
        pending_next = pending_masked;
        if (pending_masked == '0) begin
          state_next = DONE;
        end else if (expire) begin
          timed_out    = 1'b1;
          pending_next = '0;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef BCAST_TIMEOUT_EN
  logic [N_CH-1:0] dead_reg;

  bcast_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg == ISSUE),
    .enable (state_reg == WAIT),
    .expire (expire)
  );

  // A channel retired in the same cycle as revive stays retired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dead_reg <= '0;
    end else begin
      dead_reg <= (revive ? '0 : dead_reg) | (timed_out ? pending_masked : '0);
    end
  end

  assign dead_mask = dead_reg;
`else
  logic unused_cfg;

  assign expire     = 1'b0;
  assign dead_mask  = '0;
  assign unused_cfg = revive ^ timed_out ^ (TIMEOUT > 1);
`endif

  assign bus.frame_ready = (state_reg == IDLE);
  assign bus.ch_start    = (state_reg == ISSUE) ? live : '0;
  assign bus.ch_data     = data_reg;
  assign bcast_done      = (state_reg == DONE);
  assign frame_count     = count_reg;
endmodule

// File: tb/tb_broadcast_scheduler.sv
// Scoreboard bench for broadcast_scheduler; covers both BCAST_TIMEOUT_EN builds.
`timescale 1ns/1ps
module tb_broadcast_scheduler;
  import broadcast_scheduler_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_CH-1:0]  chan_en;
  logic             revive;
  logic [N_CH-1:0]  dead_mask;
  logic             bcast_done;
  logic [CNT_W-1:0] frame_count;

  broadcast_scheduler_if bus();

  broadcast_scheduler #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .chan_en     (chan_en),
    .revive      (revive),
    .dead_mask   (dead_mask),
    .bcast_done  (bcast_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MESSAGE_SIZE-1:0] data;
    logic [N_CH-1:0]         start;
  } exp_t;

  exp_t            sb_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [N_CH-1:0] seen_start = '0;
  logic [N_CH-1:0] exp_dead;
  logic [N_CH-1:0] exp_live;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a frame, wait for acceptance; returns one ns into the ISSUE cycle.
  task automatic send(input logic [MESSAGE_SIZE-1:0] d, input logic [N_CH-1:0] s);
    int guard;
    guard = 0;
    cyc();
    bus.frame_valid = 1'b1;
    bus.frame_data  = d;
    @(negedge clk);
    while (!bus.frame_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("accept", bus.frame_ready, 1'b1);
    sb_q.push_back('{data: d, start: s});
    cyc();
    bus.frame_valid = 1'b0;
  endtask

  // Counts negedges until bcast_done is seen, bounded by max.
  task automatic wait_done(input int max, output int n);
    n = 0;
    @(negedge clk);
    while (!bcast_done && n < max) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      seen_start = '0;
    end else begin
      seen_start = seen_start | bus.ch_start;
      if (bcast_done) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] bcast data=%08h start=%b count_before=%0d", bus.ch_data, seen_start, frame_count);
          check("sb_ch_data", bus.ch_data, e.data);
          check("sb_ch_start", seen_start, e.start);
        end
        seen_start = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    bus.ch_done     = '0;
    chan_en         = 4'hF;
    revive          = 1'b0;
    exp_dead        = '0;

    // Reset values while held
    @(negedge clk);
    check("rst_ready", bus.frame_ready, 1'b1);
    check("rst_start", bus.ch_start, 4'h0);
    check("rst_data", bus.ch_data, 32'h0);
    check("rst_done", bcast_done, 1'b0);
    check("rst_count", frame_count, 4'h0);
    check("rst_dead", dead_mask, 4'h0);
    cyc();
    rst = 1'b1;

    // Staggered done pulses, exact latencies
    send(32'h0000_002A, 4'hF);
    @(negedge clk);
    check("t1_start", bus.ch_start, 4'hF);
    check("t1_ready_issue", bus.frame_ready, 1'b0);
    cyc();
    @(negedge clk);
    check("t1_start_once", bus.ch_start, 4'h0);
    for (int i = 0; i < N_CH; i++) begin
      cyc();
      bus.ch_done = N_CH'(1 << i);
      @(negedge clk);
      check("t1_no_early_done", bcast_done, 1'b0);
    end
    cyc();
    bus.ch_done = '0;
    @(negedge clk);
    check("t1_bcast_done", bcast_done, 1'b1);
    check("t1_ready_done", bus.frame_ready, 1'b0);
    cyc();
    @(negedge clk);
    check("t1_count", frame_count, 4'd1);
    check("t1_ready_after", bus.frame_ready, 1'b1);
    check("t1_done_pulse", bcast_done, 1'b0);

    // All four done pulses together
    send(32'hDEAD_BEEF, 4'hF);
    cyc();
    bus.ch_done = 4'hF;
    @(negedge clk);
    check("t2_no_early_done", bcast_done, 1'b0);
    cyc();
    bus.ch_done = '0;
    @(negedge clk);
    check("t2_bcast_done", bcast_done, 1'b1);
    cyc();
    @(negedge clk);
    check("t2_single_pulse", bcast_done, 1'b0);
    check("t2_count", frame_count, 4'd2);

    // ch2 silent
    send(32'h0000_0033, 4'hF);
    cyc();
    cyc();
    bus.ch_done = 4'b1011;
    cyc();
    bus.ch_done = '0;
`ifdef BCAST_TIMEOUT_EN
    wait_done(12, n);
    check("t3_timeout_cycles", n, 6);
    check("t3_dead_mask", dead_mask, 4'b0100);
    exp_dead = 4'b0100;
`else
    wait_done(8, n);
    check("t3_still_waiting", bcast_done, 1'b0);
    check("t3_dead_mask", dead_mask, 4'b0000);
    cyc();
    bus.ch_done = 4'b0100;
    cyc();
    bus.ch_done = '0;
    @(negedge clk);
    check("t3_late_done", bcast_done, 1'b1);
`endif
    cyc();
    @(negedge clk);
    check("t3_count", frame_count, 4'd3);

    // Next frame skips retired channels
    exp_live = 4'hF & ~exp_dead;
    send(32'h0000_0044, exp_live);
    @(negedge clk);
    check("t3b_start", bus.ch_start, exp_live);
    cyc();
    bus.ch_done = exp_live;
    cyc();
    bus.ch_done = '0;
    wait_done(5, n);
    check("t3b_done_latency", n, 0);

    // revive restores every channel
    cyc();
    revive = 1'b1;
    cyc();
    revive = 1'b0;
    @(negedge clk);
    check("revive_dead", dead_mask, 4'h0);
    exp_dead = '0;
    send(32'h0000_0055, 4'hF);
    @(negedge clk);
    check("revive_start", bus.ch_start, 4'hF);

    // ch2 finishes exactly in the last WAIT cycle (0x55 frame reused)
    cyc();
    bus.ch_done = 4'b1011;
    cyc();
    bus.ch_done = '0;
    repeat (6) cyc();
    bus.ch_done = 4'b0100;
    @(negedge clk);
    check("edge_not_yet", bcast_done, 1'b0);
    cyc();
    bus.ch_done = '0;
    @(negedge clk);
    check("edge_bcast_done", bcast_done, 1'b1);
    check("edge_dead", dead_mask, 4'h0);

    // No channels enabled
    chan_en = 4'h0;
    send(32'h0000_0077, 4'h0);
    @(negedge clk);
    check("t4_start", bus.ch_start, 4'h0);
    check("t4_no_done_issue", bcast_done, 1'b0);
    cyc();
    @(negedge clk);
    check("t4_bcast_done", bcast_done, 1'b1);
    cyc();
    @(negedge clk);
    check("t4_count", frame_count, 4'd6);

    // Reset in WAIT with pending 0011
    chan_en = 4'b0011;
    send(32'h0000_0088, 4'b0011);
    cyc();
    #2;
    rst = 1'b0;
    #1;
    check("t5_ready", bus.frame_ready, 1'b1);
    check("t5_data", bus.ch_data, 32'h0);
    check("t5_count", frame_count, 4'h0);
    check("t5_done", bcast_done, 1'b0);
    check("t5_start", bus.ch_start, 4'h0);
    sb_q.delete();
    cyc();
    rst = 1'b1;
    bus.ch_done = 4'b0011;
    cyc();
    bus.ch_done = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stray_ignored", bcast_done, 1'b0);
      check("t5_ready_idle", bus.frame_ready, 1'b1);
      cyc();
    end

    // frame_count wraps (CNT_W=4)
    chan_en = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        @(negedge clk);
        check("t6_count_max", frame_count, 4'hF);
      end
      send(32'h1000_0000 + i, 4'h0);
      wait_done(4, n);
      check("t6_done_latency", n, 1);
    end
    cyc();
    @(negedge clk);
    check("t6_count_wrap", frame_count, 4'h0);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
